grid_vga_renderer: RTL

//   Consumes the flat 2000-bit board vector produced by the grid buffer and drives a 640x480@60 VGA port.

---
 rtl/tetris_vga_pkg.sv | 48 ++++
 rtl/vga_timing_gen.sv | 61 ++++++
 rtl/grid_vga_renderer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tetris_vga_pkg.sv
// Shared VGA timing constants, palette, and cell/pipeline types for the board renderer.
package tetris_vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam int HV_W      = 10;
  localparam int GRID_BITS = 2000;

  typedef logic [2:0]  cell_idx_t;
  typedef logic [23:0] rgb_t;

  localparam rgb_t RGB_BLANK      = 24'h000000;
  localparam rgb_t RGB_BACKGROUND = 24'h202020;
  localparam rgb_t RGB_GRIDLINE   = 24'h404040;

  // Everything the palette stage needs about one pixel, captured one pix_en ahead.
  typedef struct packed {
    logic      hs;
    logic      vs;
    logic      visible;
    logic      in_board;
    logic      grid_line;
    cell_idx_t idx;
  } s1_t;

  localparam s1_t S1_RESET = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};

  function automatic rgb_t palette(input cell_idx_t idx);
    case (idx)
      3'd0:    palette = 24'h000000;
      3'd1:    palette = 24'h00FFFF;
      3'd2:    palette = 24'hFFFF00;
      3'd3:    palette = 24'hA000F0;
      3'd4:    palette = 24'h00FF00;
      3'd5:    palette = 24'hFF0000;
      3'd6:    palette = 24'h0000FF;
      default: palette = 24'hFF8000;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider plus horizontal/vertical counters, raw active-low syncs and visible flag.
module vga_timing_gen
  import tetris_vga_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_FP  = H_FRONT,
  parameter int H_SW  = H_SYNC,
  parameter int H_BP  = H_BACK,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_FP  = V_FRONT,
  parameter int V_SW  = V_SYNC,
  parameter int V_BP  = V_BACK
) (
  input  logic            clock,
  input  logic            reset,
  output logic            pix_en,
  output logic [HV_W-1:0] h,
  output logic [HV_W-1:0] v,
  output logic            hs_raw,
  output logic            vs_raw,
  output logic            visible
);

  localparam logic [HV_W-1:0] H_LAST    = HV_W'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam logic [HV_W-1:0] V_LAST    = HV_W'(V_ACT + V_FP + V_SW + V_BP - 1);
  localparam logic [HV_W-1:0] HS_BEGIN  = HV_W'(H_ACT + H_FP);
  localparam logic [HV_W-1:0] HS_END    = HV_W'(H_ACT + H_FP + H_SW);
  localparam logic [HV_W-1:0] VS_BEGIN  = HV_W'(V_ACT + V_FP);
  localparam logic [HV_W-1:0] VS_END    = HV_W'(V_ACT + V_FP + V_SW);
  localparam logic [HV_W-1:0] H_VIS_END = HV_W'(H_ACT);
  localparam logic [HV_W-1:0] V_VIS_END = HV_W'(V_ACT);

  logic phase;

  // phase is 0 out of reset, so the first pix_en lands on the second clock after release.
  assign pix_en = phase;

  // NOTE: all state here uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= 1'b0;
      h     <= '0;
      v     <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (h == H_LAST) begin
          h <= '0;
          v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
      end
    end
  end

  assign hs_raw  = !((h >= HS_BEGIN) && (h < HS_END));
  assign vs_raw  = !((v >= VS_BEGIN) && (v < VS_END));
  assign visible = (h < H_VIS_END) && (v < V_VIS_END);

endmodule

// File: rtl/grid_vga_renderer.sv
// Board-to-VGA renderer: per-frame snapshot, divider-free cell tracking, 2-stage pixel pipeline.
// Optional GRID_LINES_EN draws 404040 on the first row/column of pixels of every board cell.
module grid_vga_renderer
  import tetris_vga_pkg::*;
#(
  parameter int COLS    = 10,
  parameter int ROWS    = 20,
  parameter int SLOT_W  = 10,
  parameter int CELL_PX = 16,
  parameter int X0      = 240,
  parameter int Y0      = 80,
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FP    = H_FRONT,
  parameter int H_SW    = H_SYNC,
  parameter int H_BP    = H_BACK,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FP    = V_FRONT,
  parameter int V_SW    = V_SYNC,
  parameter int V_BP    = V_BACK
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [GRID_BITS-1:0] grid_data,
  input  logic                 snap_hold,
  output logic                 frame_done,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_blank_n,
  output logic [7:0]           vga_r,
  output logic [7:0]           vga_g,
  output logic [7:0]           vga_b
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SW + V_BP;
  localparam int CELLS   = ROWS * COLS;
  localparam int IDX_W   = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int COL_W   = $clog2(COLS + 1);
  localparam int ROW_W   = $clog2(ROWS + 1);
  localparam int SUB_W   = $clog2(CELL_PX);

  typedef logic [HV_W-1:0] pos_t;

  localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
  localparam pos_t H_PRE_X0 = pos_t'((X0 == 0) ? H_TOTAL - 1 : X0 - 1);
  localparam pos_t V_PRE_Y0 = pos_t'((Y0 == 0) ? V_TOTAL - 1 : Y0 - 1);
  localparam pos_t X_START  = pos_t'(X0);
  localparam pos_t X_END    = pos_t'(X0 + COLS * CELL_PX);
  localparam pos_t Y_START  = pos_t'(Y0);
  localparam pos_t Y_END    = pos_t'(Y0 + ROWS * CELL_PX);
  localparam pos_t SNAP_V   = pos_t'(V_ACT);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

  logic pix_en, hs_raw, vs_raw, visible;
  pos_t h, v;

  vga_timing_gen #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) u_timing (
    .clock   (clock),
    .reset   (reset),
    .pix_en  (pix_en),
    .h       (h),
    .v       (v),
    .hs_raw  (hs_raw),
    .vs_raw  (vs_raw),
    .visible (visible)
  );

  // Only the 3-bit colour index of each slot is kept; the rest of grid_data is ignored.
  cell_idx_t [CELLS-1:0] grid_cells;
  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cells
    assign grid_cells[gi] = grid_data[gi*SLOT_W +: 3];
  end

  logic unused_grid;
  assign unused_grid = ^grid_data;

  cell_idx_t [CELLS-1:0] snap_q;
  logic                  snap_load;

  assign snap_load = pix_en && (h == '0) && (v == SNAP_V) && !snap_hold;

  // NOTE: the snapshot must read as all-empty after reset, so it is cleared like any other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= snap_load;
      if (snap_load) snap_q <= grid_cells;
    end
  end

  // Cell counters mirror h/v: restarted one step before the board edge, stepped every CELL_PX.
  logic [SUB_W-1:0] sub_x, sub_y;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  always_ff @(posedge clock) begin
    if (reset) begin
      sub_x <= '0;
      sub_y <= '0;
      col   <= '0;
      row   <= '0;
    end else if (pix_en) begin
      if (h == H_PRE_X0) begin
        sub_x <= '0;
        col   <= '0;
      end else if (sub_x == SUB_LAST) begin
        sub_x <= '0;
        col   <= col + 1'b1;
      end else begin
        sub_x <= sub_x + 1'b1;
      end

      if (h == H_LAST) begin
        if (v == V_PRE_Y0) begin
          sub_y <= '0;
          row   <= '0;
        end else if (sub_y == SUB_LAST) begin
          sub_y <= '0;
          row   <= row + 1'b1;
        end else begin
          sub_y <= sub_y + 1'b1;
        end
      end
    end
  end

  logic             in_board;
  logic [IDX_W-1:0] cell_sel;
  s1_t              s1_d, s1_q;

  always_comb begin
    in_board = (h >= X_START) && (h < X_END) && (v >= Y_START) && (v < Y_END);
    cell_sel = in_board ? IDX_W'(int'(row) * COLS + int'(col)) : '0;

    s1_d.hs       = hs_raw;
    s1_d.vs       = vs_raw;
    s1_d.visible  = visible;
    s1_d.in_board = in_board;
    s1_d.idx      = snap_q[cell_sel];
`ifdef GRID_LINES_EN
    s1_d.grid_line = (sub_x == '0) || (sub_y == '0);
`else
    s1_d.grid_line = 1'b0;
`endif
  end

  rgb_t pix_rgb;

  always_comb begin
    // NOTE: default first so every path assigns pix_rgb and no latch is inferred.
    pix_rgb = RGB_BLANK;
    if (s1_q.visible) begin
      if (!s1_q.in_board)      pix_rgb = RGB_BACKGROUND;
      else if (s1_q.grid_line) pix_rgb = RGB_GRIDLINE;
      else                     pix_rgb = palette(s1_q.idx);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q                  <= S1_RESET;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
      vga_blank_n           <= 1'b0;
      {vga_r, vga_g, vga_b} <= RGB_BLANK;
    end else if (pix_en) begin
      s1_q                  <= s1_d;
      vga_hs                <= s1_q.hs;
      vga_vs                <= s1_q.vs;
      vga_blank_n           <= s1_q.visible;
      {vga_r, vga_g, vga_b} <= pix_rgb;
    end
  end

endmodule
